// File: rtl/ysyx_23060061_lsu_pipe.sv
// Registered load/store unit between EXU and WBU with a single-outstanding memory port.
// Define YSYX_23060061_LSU_ALIGN_CHECK_EN to fault misaligned accesses without a request.
module ysyx_23060061_lsu_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mem_rw,
  input  logic [2:0]          mem_ext,
  input  logic [1:0]          mem_size,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_we,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W-1:0]   req_wdata,
  output logic [DATA_W/8-1:0] req_wstrb,
  input  logic                rsp_valid,
  input  logic [DATA_W-1:0]   rsp_rdata,
  input  logic                rsp_err
);
  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned OffW  = $clog2(StrbW);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                req_we_q, req_we_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [StrbW-1:0]    req_wstrb_q, req_wstrb_d;
  logic [OffW-1:0]     off_q, off_d;
  logic [2:0]          ext_q, ext_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [OffW-1:0]     in_off;
  logic                is_load, is_store, ext_ok, size_ok, misal;
  logic [StrbW-1:0]    strb_sh;
  logic [DATA_W-1:0]   wdata_sh;
  logic [DATA_W-1:0]   rsp_shift, load_data;

  assign in_off   = addr[OffW-1:0];
  assign is_load  = (mem_rw == 2'b10);
  assign is_store = (mem_rw == 2'b01);

  always_comb begin
    ext_ok = 1'b0;
    case (mem_ext)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b100: ext_ok = 1'b1;
      3'b101, 3'b110:                         ext_ok = (DATA_W == 64);
      default:                                ext_ok = 1'b0;
    endcase
  end

  assign size_ok = (mem_size != 2'd3) || (DATA_W == 64);

`ifdef YSYX_23060061_LSU_ALIGN_CHECK_EN
  logic [1:0]      acc_lg;
  logic [OffW-1:0] align_mask;

  // log2 of the access size in bytes; a raw load spans the full data word
  always_comb begin
    acc_lg = mem_size;
    if (is_load) begin
      case (mem_ext)
        3'b001, 3'b011: acc_lg = 2'd0;
        3'b010, 3'b100: acc_lg = 2'd1;
        3'b101, 3'b110: acc_lg = 2'd2;
        default:        acc_lg = 2'(OffW);
      endcase
    end
  end

  assign align_mask = OffW'((32'd1 << acc_lg) - 32'd1);
  assign misal      = |(in_off & align_mask);
`else
  assign misal = 1'b0;
`endif

  // Lanes shifted past the top of the word fall off here by truncation.
  assign strb_sh  = StrbW'((16'd1 << (16'd1 << mem_size)) - 16'd1) << in_off;
  assign wdata_sh = wdata << {in_off, 3'b000};

  assign rsp_shift = rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = rsp_shift;
    case (ext_q)
      3'b001:  load_data = DATA_W'($signed(rsp_shift[7:0]));
      3'b010:  load_data = DATA_W'($signed(rsp_shift[15:0]));
      3'b011:  load_data = DATA_W'(rsp_shift[7:0]);
      3'b100:  load_data = DATA_W'(rsp_shift[15:0]);
      3'b101:  load_data = DATA_W'($signed(rsp_shift[31:0]));
      3'b110:  load_data = DATA_W'(rsp_shift[31:0]);
      default: load_data = rsp_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    off_d       = off_q;
    ext_d       = ext_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          off_d       = in_off;
          ext_d       = mem_ext;
          rdata_d     = '0;
          err_d       = 1'b0;
          req_addr_d  = {addr[ADDR_W-1:OffW], {OffW{1'b0}}};
          req_we_d    = is_store;
          req_wdata_d = is_store ? wdata_sh : '0;
          req_wstrb_d = is_store ? strb_sh : '0;
          if (mem_rw == 2'b00) begin
            state_d = StResp;
          end else if ((mem_rw == 2'b11) || (is_load && !ext_ok) ||
                       (is_store && !size_ok) || misal) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (req_ready) state_d = StWait;
      end
      StWait: begin
        if (rsp_valid) begin
          rdata_d = req_we_q ? '0 : load_data;
          err_d   = rsp_err;
          state_d = StResp;
        end
      end
      StResp: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      off_q       <= '0;
      ext_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      off_q       <= off_d;
      ext_q       <= ext_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // in_ready is gated by rst_n so it reads low for the whole reset assertion.
  assign in_ready  = rst_n & (state_q == StIdle);
  assign out_valid = (state_q == StResp);
  assign req_valid = (state_q == StReq);
  assign req_we    = req_we_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign req_wstrb = req_wstrb_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ysyx_23060061_lsu_pipe.sv
// Vector table plus scoreboard bench for ysyx_23060061_lsu_pipe at DATA_W=32 and DATA_W=64.
module tb_ysyx_23060061_lsu_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid32, in_valid64, out_ready, req_ready, rsp_valid, rsp_err;
  logic [1:0]  mem_rw, mem_size;
  logic [2:0]  mem_ext;
  logic [31:0] addr;
  logic [63:0] wdata, rsp_rdata;

  logic        in_ready32, out_valid32, err32, req_valid32, req_we32;
  logic [31:0] rdata32, req_addr32, req_wdata32;
  logic [3:0]  req_wstrb32;
  logic        in_ready64, out_valid64, err64, req_valid64, req_we64;
  logic [63:0] rdata64, req_wdata64;
  logic [31:0] req_addr64;
  logic [7:0]  req_wstrb64;

  ysyx_23060061_lsu_pipe #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .mem_rw(mem_rw), .mem_ext(mem_ext), .mem_size(mem_size), .addr(addr),
    .wdata(wdata[31:0]), .out_valid(out_valid32), .out_ready(out_ready), .rdata(rdata32),
    .err(err32), .req_valid(req_valid32), .req_ready(req_ready), .req_we(req_we32),
    .req_addr(req_addr32), .req_wdata(req_wdata32), .req_wstrb(req_wstrb32),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata[31:0]), .rsp_err(rsp_err)
  );

  ysyx_23060061_lsu_pipe #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .mem_rw(mem_rw), .mem_ext(mem_ext), .mem_size(mem_size), .addr(addr),
    .wdata(wdata), .out_valid(out_valid64), .out_ready(out_ready), .rdata(rdata64),
    .err(err64), .req_valid(req_valid64), .req_ready(req_ready), .req_we(req_we64),
    .req_addr(req_addr64), .req_wdata(req_wdata64), .req_wstrb(req_wstrb64),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  bit          sel64;
  logic        a_in_ready, a_out_valid, a_err, a_req_valid, a_req_we;
  logic [63:0] a_rdata, a_req_wdata;
  logic [31:0] a_req_addr;
  logic [7:0]  a_req_wstrb;

  always_comb begin
    a_in_ready  = sel64 ? in_ready64  : in_ready32;
    a_out_valid = sel64 ? out_valid64 : out_valid32;
    a_err       = sel64 ? err64       : err32;
    a_req_valid = sel64 ? req_valid64 : req_valid32;
    a_req_we    = sel64 ? req_we64    : req_we32;
    a_rdata     = sel64 ? rdata64     : {32'b0, rdata32};
    a_req_wdata = sel64 ? req_wdata64 : {32'b0, req_wdata32};
    a_req_addr  = sel64 ? req_addr64  : req_addr32;
    a_req_wstrb = sel64 ? req_wstrb64 : {4'b0, req_wstrb32};
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          w64;
    logic [1:0]  rw;
    logic [2:0]  ext;
    logic [1:0]  size;
    logic [31:0] a;
    logic [63:0] wd;
    logic [63:0] mem_rd;
    logic        mem_err;
    bit          xreq;
    logic [31:0] xaddr;
    logic        xwe;
    logic [63:0] xwd;
    logic [7:0]  xstrb;
    logic [63:0] xrd;
    logic        xerr;
    int          req_stall;
    int          rsp_dly;
    int          out_stall;
  } vec_t;

  typedef struct {
    logic [63:0] rd;
    logic        e;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  function automatic vec_t mk(string name, bit w64, logic [1:0] rw, logic [2:0] ext,
                              logic [1:0] size, logic [31:0] a, logic [63:0] wd,
                              logic [63:0] mem_rd, logic mem_err, bit xreq, logic [31:0] xaddr,
                              logic xwe, logic [63:0] xwd, logic [7:0] xstrb, logic [63:0] xrd,
                              logic xerr, int rs, int rd, int os);
    vec_t v;
    v.name = name; v.w64 = w64; v.rw = rw; v.ext = ext; v.size = size; v.a = a; v.wd = wd;
    v.mem_rd = mem_rd; v.mem_err = mem_err; v.xreq = xreq; v.xaddr = xaddr; v.xwe = xwe;
    v.xwd = xwd; v.xstrb = xstrb; v.xrd = xrd; v.xerr = xerr;
    v.req_stall = rs; v.rsp_dly = rd; v.out_stall = os;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   c, rq, wt;
    bit   req_done, req_seen, done;
    @(negedge clk);
    sel64 = v.w64; mem_rw = v.rw; mem_ext = v.ext; mem_size = v.size; addr = v.a;
    wdata = v.wd; in_valid32 = !v.w64; in_valid64 = v.w64;
    #1;
    check({v.name, ".in_ready_idle"}, 64'(a_in_ready), 64'd1);
    e.rd = v.xrd; e.e = v.xerr;
    sb_q.push_back(e);
    @(posedge clk);
    #1 in_valid32 = 1'b0; in_valid64 = 1'b0;
    c = 0; rq = 0; wt = 0; req_done = 0; req_seen = 0; done = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (a_out_valid) begin
        done = 1;
      end else begin
        check({v.name, ".in_ready_busy"}, 64'(a_in_ready), 64'd0);
        if (a_req_valid) begin
          req_seen = 1;
          check({v.name, ".req_addr"}, 64'(a_req_addr), 64'(v.xaddr));
          check({v.name, ".req_we"}, 64'(a_req_we), 64'(v.xwe));
          check({v.name, ".req_wdata"}, a_req_wdata, v.xwd);
          check({v.name, ".req_wstrb"}, 64'(a_req_wstrb), 64'(v.xstrb));
          req_ready = (rq == v.req_stall);
          // a stray response while the request is pending must be ignored
          rsp_valid = !req_ready;
          rsp_rdata = ~v.mem_rd;
          rsp_err   = 1'b1;
          rq++;
          if (req_ready) req_done = 1;
        end else if (req_done) begin
          rsp_valid = (wt == v.rsp_dly);
          rsp_rdata = v.mem_rd;
          rsp_err   = v.mem_err;
          wt++;
        end
        @(posedge clk);
        #1 req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
      end
    end
    check({v.name, ".out_valid_seen"}, 64'(done), 64'd1);
    check({v.name, ".req_issued"}, 64'(req_seen), 64'(v.xreq));
    check({v.name, ".latency"}, 64'(c),
          64'(v.xreq ? 3 + v.req_stall + v.rsp_dly : 1));
    e = sb_q.pop_front();
    if (done) begin
      for (int k = 0; k <= v.out_stall; k++) begin
        check({v.name, ".out_valid"}, 64'(a_out_valid), 64'd1);
        check({v.name, ".rdata"}, a_rdata, e.rd);
        check({v.name, ".err"}, 64'(a_err), 64'(e.e));
        check({v.name, ".in_ready_resp"}, 64'(a_in_ready), 64'd0);
        out_ready = (k == v.out_stall);
        @(posedge clk);
        #1 out_ready = 1'b0;
        if (k < v.out_stall) @(negedge clk);
      end
      @(negedge clk);
      check({v.name, ".out_valid_drop"}, 64'(a_out_valid), 64'd0);
      check({v.name, ".in_ready_back"}, 64'(a_in_ready), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid32 = 1'b0; in_valid64 = 1'b0; out_ready = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
    mem_rw = '0; mem_ext = '0; mem_size = '0; addr = '0; wdata = '0; sel64 = 0;

    vecs.push_back(mk("lb_neg", 0, 2'b10, 3'b001, 2'd0, 32'h8000_0003, 64'h0, 64'h80FF_FFFF, 0,
                      1, 32'h8000_0000, 0, 64'h0, 8'h0, 64'hFFFF_FF80, 0, 0, 0, 0));
    vecs.push_back(mk("sh_hi", 0, 2'b01, 3'b000, 2'd1, 32'h8000_0002, 64'h1234_ABCD,
                      64'hDEAD_BEEF, 0, 1, 32'h8000_0000, 1, 64'hABCD_0000, 8'h0C, 64'h0, 0,
                      0, 0, 0));
    vecs.push_back(mk("lhu_stall", 0, 2'b10, 3'b100, 2'd0, 32'h8000_0006, 64'h0, 64'hBEEF_1234,
                      0, 1, 32'h8000_0004, 0, 64'h0, 8'h0, 64'h0000_BEEF, 0, 3, 2, 2));
    vecs.push_back(mk("rw_ill", 0, 2'b11, 3'b000, 2'd0, 32'h8000_0000, 64'h0, 64'h0, 0,
                      0, 32'h0, 0, 64'h0, 8'h0, 64'h0, 1, 0, 0, 0));
    vecs.push_back(mk("nop", 0, 2'b00, 3'b000, 2'd0, 32'h8000_0000, 64'h0, 64'h0, 0,
                      0, 32'h0, 0, 64'h0, 8'h0, 64'h0, 0, 0, 0, 1));
    vecs.push_back(mk("ld_buserr", 0, 2'b10, 3'b000, 2'd0, 32'h0000_0100, 64'h0, 64'h1122_3344,
                      1, 1, 32'h0000_0100, 0, 64'h0, 8'h0, 64'h1122_3344, 1, 0, 1, 0));
    vecs.push_back(mk("sb", 0, 2'b01, 3'b000, 2'd0, 32'h1000_0001, 64'hFFFF_FFAB, 64'h0, 0,
                      1, 32'h1000_0000, 1, 64'hFFFF_AB00, 8'h02, 64'h0, 0, 1, 0, 0));
    vecs.push_back(mk("lh_neg", 0, 2'b10, 3'b010, 2'd0, 32'h0000_0002, 64'h0, 64'h8001_7777, 0,
                      1, 32'h0, 0, 64'h0, 8'h0, 64'hFFFF_8001, 0, 0, 0, 0));
    vecs.push_back(mk("lw_on32", 0, 2'b10, 3'b101, 2'd0, 32'h0, 64'h0, 64'h0, 0,
                      0, 32'h0, 0, 64'h0, 8'h0, 64'h0, 1, 0, 0, 0));
    vecs.push_back(mk("sd_on32", 0, 2'b01, 3'b000, 2'd3, 32'h0, 64'h5, 64'h0, 0,
                      0, 32'h0, 0, 64'h0, 8'h0, 64'h0, 1, 0, 0, 0));
`ifdef YSYX_23060061_LSU_ALIGN_CHECK_EN
    vecs.push_back(mk("ld_misal", 0, 2'b10, 3'b000, 2'd0, 32'h8000_0002, 64'h0, 64'hAABB_CCDD,
                      0, 0, 32'h0, 0, 64'h0, 8'h0, 64'h0, 1, 0, 0, 0));
    vecs.push_back(mk("sw_misal", 0, 2'b01, 3'b000, 2'd2, 32'h0000_0003, 64'h1122_3344, 64'h0,
                      0, 0, 32'h0, 0, 64'h0, 8'h0, 64'h0, 1, 0, 0, 0));
    vecs.push_back(mk("lw64_misal", 1, 2'b10, 3'b101, 2'd0, 32'h0000_0002, 64'h0, 64'h0, 0,
                      0, 32'h0, 0, 64'h0, 8'h0, 64'h0, 1, 0, 0, 0));
`else
    vecs.push_back(mk("ld_misal", 0, 2'b10, 3'b000, 2'd0, 32'h8000_0002, 64'h0, 64'hAABB_CCDD,
                      0, 1, 32'h8000_0000, 0, 64'h0, 8'h0, 64'h0000_AABB, 0, 0, 0, 0));
    vecs.push_back(mk("sw_misal", 0, 2'b01, 3'b000, 2'd2, 32'h0000_0003, 64'h1122_3344, 64'h0,
                      0, 1, 32'h0, 1, 64'h4400_0000, 8'h08, 64'h0, 0, 0, 0, 0));
`endif
    vecs.push_back(mk("lw64", 1, 2'b10, 3'b101, 2'd0, 32'h8000_0004, 64'h0,
                      64'h8000_0001_0000_0000, 0, 1, 32'h8000_0000, 0, 64'h0, 8'h0,
                      64'hFFFF_FFFF_8000_0001, 0, 0, 0, 0));
    vecs.push_back(mk("lwu64", 1, 2'b10, 3'b110, 2'd0, 32'h8000_0004, 64'h0,
                      64'h8000_0001_0000_0000, 0, 1, 32'h8000_0000, 0, 64'h0, 8'h0,
                      64'h0000_0000_8000_0001, 0, 1, 1, 0));
    vecs.push_back(mk("sd64", 1, 2'b01, 3'b000, 2'd3, 32'h0000_0008, 64'h0123_4567_89AB_CDEF,
                      64'h0, 0, 1, 32'h0000_0008, 1, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 0,
                      0, 0, 0));
    vecs.push_back(mk("sw64_hi", 1, 2'b01, 3'b000, 2'd2, 32'h0000_0004, 64'hDEAD_BEEF, 64'h0, 0,
                      1, 32'h0, 1, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h0, 0, 0, 0, 0));
    vecs.push_back(mk("lb64_top", 1, 2'b10, 3'b001, 2'd0, 32'h0000_0017, 64'h0,
                      64'h7F00_0000_0000_0000, 0, 1, 32'h0000_0010, 0, 64'h0, 8'h0, 64'h7F, 0,
                      0, 0, 0));
    vecs.push_back(mk("ext7_64", 1, 2'b10, 3'b111, 2'd0, 32'h0, 64'h0, 64'h0, 0,
                      0, 32'h0, 0, 64'h0, 8'h0, 64'h0, 1, 0, 0, 0));

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", 64'(in_ready32), 64'd0);
    check("rst.out_valid", 64'(out_valid32), 64'd0);
    check("rst.req_valid", 64'(req_valid32), 64'd0);
    check("rst.rdata", 64'(rdata32), 64'd0);
    check("rst.err", 64'(err32), 64'd0);
    check("rst.req_we", 64'(req_we32), 64'd0);
    check("rst.req_wstrb", 64'(req_wstrb32), 64'd0);
    check("rst.rdata64", rdata64, 64'd0);
    rst_n = 1'b1;
    #1 check("rst.in_ready_release", 64'(in_ready32), 64'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting for a response; the late response must be dropped.
    @(negedge clk);
    sel64 = 0; mem_rw = 2'b10; mem_ext = 3'b000; addr = 32'h0000_0040; in_valid32 = 1'b1;
    @(posedge clk);
    #1 in_valid32 = 1'b0;
    @(negedge clk);
    check("wrst.req_valid", 64'(req_valid32), 64'd1);
    req_ready = 1'b1;
    @(posedge clk);
    #1 req_ready = 1'b0;
    @(negedge clk);
    check("wrst.wait_no_out", 64'(out_valid32), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("wrst.in_ready", 64'(in_ready32), 64'd0);
    check("wrst.out_valid", 64'(out_valid32), 64'd0);
    check("wrst.req_valid", 64'(req_valid32), 64'd0);
    check("wrst.rdata", 64'(rdata32), 64'd0);
    rst_n = 1'b1; rsp_valid = 1'b1; rsp_rdata = 64'h5555_5555; rsp_err = 1'b1;
    @(posedge clk);
    #1 rsp_valid = 1'b0; rsp_err = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wrst.late_rsp_out", 64'(out_valid32), 64'd0);
      check("wrst.late_rsp_ready", 64'(in_ready32), 64'd1);
    end
    run_vec(mk("post_rst_lbu", 0, 2'b10, 3'b011, 2'd0, 32'h0000_0041, 64'h0, 64'h0000_9A00, 0,
               1, 32'h0000_0040, 0, 64'h0, 8'h0, 64'h0000_009A, 0, 0, 0, 0));

    check("sb.empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_lsu_pipe.md
# ysyx_23060061_lsu_pipe

Parametrised load/store unit between EXU and WBU. It replaces the combinational DPI memory access with a registered, single-outstanding request/response memory port and valid/ready handshakes on both pipeline sides. It adds address-based byte-lane alignment, store strobe generation, 32/64-bit data width and error reporting. Sits between `ysyx_23060061_EXU` and `ysyx_23060061_WBU`; the memory side connects to the data SRAM/bus bridge.

## Interface
- `DATA_W`, default 32: data/register width; legal values 32 or 64.
- `ADDR_W`, default 32: address width.
- `clk` in 1: the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: EXU offers an operation.
- `in_ready` out 1: LSU can accept; high only in IDLE.
- `mem_rw` in 2: 2'b10 load, 2'b01 store, 2'b00 no memory op, 2'b11 illegal.
- `mem_ext` in 3: load extension. 000 raw, 001 lb, 010 lh, 011 lbu, 100 lhu, 101 lw (DATA_W=64 only), 110 lwu (DATA_W=64 only).
- `mem_size` in 2: store size. 0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only).
- `addr` in ADDR_W: byte address.
- `wdata` in DATA_W: store data, right-aligned.
- `out_valid` out 1: result available to WBU.
- `out_ready` in 1: WBU accepts the result.
- `rdata` out DATA_W: extended, right-aligned load data; 0 for stores and non-memory ops.
- `err` out 1: access fault; qualified by `out_valid`.
- `req_valid` out 1: memory request.
- `req_ready` in 1: memory accepts the request.
- `req_we` out 1: 1 for store.
- `req_addr` out ADDR_W: `addr` with the low log2(DATA_W/8) bits cleared.
- `req_wdata` out DATA_W: store data shifted to its byte lanes.
- `req_wstrb` out DATA_W/8: byte enables.
- `rsp_valid` in 1: memory response; sent for loads and stores.
- `rsp_rdata` in DATA_W: full-word read data.
- `rsp_err` in 1: bus error.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `in_ready`=1. On `in_valid`, latch all inputs.
  - `mem_rw`=00 → RESP with rdata 0, err 0.
  - `mem_rw`=11, or an ext/size code illegal for DATA_W → RESP with err 1.
  - Otherwise → REQ.
- REQ: `req_valid`=1; all `req_*` outputs held stable until `req_ready`. On `req_ready` → WAIT.
- WAIT: on `rsp_valid` → RESP.
  - Register the rdata computation: shift `rsp_rdata` right by 8×addr[low bits], then extend per `mem_ext`.
  - Register `err` = `rsp_err`.
- RESP: `out_valid`=1; `rdata` and `err` held until `out_ready`, then → IDLE. No new acceptance in the same cycle.
- `req_wstrb`: size mask (1, 3, 0xF, 0xFF) shifted left by the addr low bits. `req_wdata`: `wdata` shifted left by 8× the same amount.
- `rsp_valid` outside WAIT is ignored.
- Only one operation is in flight at a time.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after reset release. `out_valid`=0, `req_valid`=0, `rdata`=0, `err`=0, `req_we`=0, `req_wstrb`=0; state=IDLE.
- Accept in cycle 0 → `req_valid` in cycle 1.
- With `req_ready`=1 in cycle 1 and `rsp_valid`=1 in cycle 2, `out_valid` rises in cycle 3. Each memory stall cycle adds one cycle.
- Non-memory and illegal ops: `out_valid` rises in cycle 1.
- Reset asserted in any state → IDLE on the next edge. All outputs return to their reset values; any pending memory response is dropped.

## Configuration
- `YSYX_23060061_LSU_ALIGN_CHECK_EN` defined: a misaligned access (half at odd address, word not 4-aligned, dword not 8-aligned) issues no memory request. It goes IDLE→RESP with err 1 and rdata 0.
- Macro undefined: no check. Misaligned accesses are issued, and lanes past the word boundary are silently dropped from `req_wstrb` and rdata.

## Test plan
- DATA_W=32, lb at addr 0x8000_0003, `rsp_rdata`=0x80FF_FFFF, zero-wait memory → rdata 0xFFFF_FF80, `out_valid` in cycle 3.
- sh of `wdata`=0x1234_ABCD at 0x8000_0002 → `req_wstrb`=4'b1100, `req_wdata`=0xABCD_0000, `req_addr`=0x8000_0000, `req_we`=1.
- Load with `req_ready` low for 3 cycles, then `rsp_valid` delayed 2 cycles, then `out_ready` low for 2 cycles → `req_*` stable throughout, `in_ready` low throughout, one `out_valid` pulse train, lhu result correct.
- `mem_rw`=11 → `out_valid` in cycle 1 with err=1 and no `req_valid`. `rsp_err`=1 on a load → err=1.
- DATA_W=64, lw at addr offset 4 with `rsp_rdata`=0x8000_0001_0000_0000 → rdata 0xFFFF_FFFF_8000_0001. lwu → 0x0000_0000_8000_0001.
- `rst_n` low while in WAIT, then a late `rsp_valid` → the late response is ignored, `out_valid` stays 0, and the next load completes normally. With the macro defined, lw at 0x...2 → err=1 and no request issued.
